dmem_arbiter: RTL and testbench

- Arbitrates the single-port data memory between two requesters: the pipeline core's load/store port (port C) and a debug/loader master (port D), which performs testbench or boot-time memory access.
- Sits in the top level between the core's MEM stage, the debug port and the data memory macro.
- Core has priority. A starvation counter guarantees that port D makes progress.
- Read data returns one cycle after grant, because the data memory reads synchronously.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_starve_ctr.sv | 36 +++
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   owner_e   : which port owns the read data returning this cycle
//   mem_req_t : one memory access (write enable, word address, write data)
package dmem_arb_pkg;

    localparam int unsigned WAIT_CNT_W  = 4;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_ADDR_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Starvation counter for a low-priority requester: counts consecutive denied
// cycles, saturates at P_MAX_WAIT and then asks the arbiter to force a win.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_req          : low-priority request
//   i_gnt          : low-priority grant this cycle
//   o_force_c      : counter has reached P_MAX_WAIT (combinational)
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned P_MAX_WAIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_force_c
);

    localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(P_MAX_WAIT);

    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    // Clear on grant, count denied cycles, hold when not requesting.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (i_gnt) begin
            r_wait_cnt <= '0;
        end else if (i_req && (r_wait_cnt != MAX_CNT)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
        end
    end

    assign o_force_c = (r_wait_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core load/store port (C, priority)
// and a debug/loader master (D, guaranteed progress via a starvation counter).
// Grants are combinational; read data returns the cycle after a read grant.
//   i_core_* / o_core_* : core request bundle, grant, stall, read return
//   i_dbg_*  / o_dbg_*  : debug request bundle, grant, read return
//   o_mem_* / i_mem_rdata : data memory macro interface (synchronous read)
// Optional build macro DMEM_ARB_STATS_EN adds 32-bit grant/conflict counters
// o_stat_core_cnt, o_stat_dbg_cnt, o_stat_conflict_cnt.
// Bus widths above the package widths are truncated by the internal bus struct.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH      = 32,
    parameter int unsigned P_DMEM_ADDR_WIDTH = 8,
    parameter int unsigned P_MAX_WAIT        = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_core_req,
    input  logic                         i_core_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_core_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_core_wdata,
    output logic                         o_core_gnt,
    output logic                         o_core_stall,
    output logic                         o_core_rvalid,
    output logic [P_DATA_WIDTH-1:0]      o_core_rdata,
    input  logic                         i_dbg_req,
    input  logic                         i_dbg_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_dbg_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_dbg_wdata,
    output logic                         o_dbg_gnt,
    output logic                         o_dbg_rvalid,
    output logic [P_DATA_WIDTH-1:0]      o_dbg_rdata,
    output logic                         o_mem_en,
    output logic                         o_mem_we,
    output logic [P_DMEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [P_DATA_WIDTH-1:0]      o_mem_wdata,
    input  logic [P_DATA_WIDTH-1:0]      i_mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]                  o_stat_core_cnt,
    output logic [31:0]                  o_stat_dbg_cnt,
    output logic [31:0]                  o_stat_conflict_cnt
`endif
);

    logic     w_force_dbg;
    logic     w_core_gnt;
    logic     w_dbg_gnt;
    mem_req_t w_core_bus;
    mem_req_t w_dbg_bus;
    mem_req_t w_mem_req;
    owner_e   r_rd_owner;
    owner_e   w_rd_owner_nxt;

    dmem_arb_starve_ctr #(
        .P_MAX_WAIT (P_MAX_WAIT)
    ) u_starve_ctr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_dbg_req),
        .i_gnt     (w_dbg_gnt),
        .o_force_c (w_force_dbg)
    );

    // Winner select: D wins alone or when starved; grants held off during reset.
    always_comb begin
        w_core_gnt = 1'b0;
        w_dbg_gnt  = 1'b0;
        if (i_rst_n) begin
            if (i_dbg_req && (!i_core_req || w_force_dbg)) begin
                w_dbg_gnt = 1'b1;
            end else if (i_core_req) begin
                w_core_gnt = 1'b1;
            end
        end
    end

    assign o_core_gnt   = w_core_gnt;
    assign o_dbg_gnt    = w_dbg_gnt;
    assign o_core_stall = i_rst_n & i_core_req & ~w_core_gnt;

    assign w_core_bus = '{we: i_core_we, addr: DMEM_ADDR_W'(i_core_addr),
                          wdata: DMEM_DATA_W'(i_core_wdata)};
    assign w_dbg_bus  = '{we: i_dbg_we, addr: DMEM_ADDR_W'(i_dbg_addr),
                          wdata: DMEM_DATA_W'(i_dbg_wdata)};

    // Memory mux; idle cycles park on the core bundle with writes disabled.
    always_comb begin
        w_mem_req    = w_core_bus;
        w_mem_req.we = 1'b0;
        if (w_dbg_gnt) begin
            w_mem_req = w_dbg_bus;
        end else if (w_core_gnt) begin
            w_mem_req = w_core_bus;
        end
    end

    assign o_mem_en    = w_core_gnt | w_dbg_gnt;
    assign o_mem_we    = w_mem_req.we;
    assign o_mem_addr  = P_DMEM_ADDR_WIDTH'(w_mem_req.addr);
    assign o_mem_wdata = P_DATA_WIDTH'(w_mem_req.wdata);

    // Read-owner state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_owner <= OWN_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    // Read-owner next state: rewritten every cycle by the current read grant.
    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (w_core_gnt && !i_core_we) begin
            w_rd_owner_nxt = OWN_CORE;
        end else if (w_dbg_gnt && !i_dbg_we) begin
            w_rd_owner_nxt = OWN_DBG;
        end
    end

    // Read-return outputs; a read in flight when reset asserts is discarded.
    always_comb begin
        o_core_rvalid = 1'b0;
        o_core_rdata  = '0;
        o_dbg_rvalid  = 1'b0;
        o_dbg_rdata   = '0;
        if (i_rst_n) begin
            case (r_rd_owner)
                OWN_CORE: begin
                    o_core_rvalid = 1'b1;
                    o_core_rdata  = i_mem_rdata;
                end
                OWN_DBG: begin
                    o_dbg_rvalid = 1'b1;
                    o_dbg_rdata  = i_mem_rdata;
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_stat_core_cnt;
    logic [31:0] r_stat_dbg_cnt;
    logic [31:0] r_stat_conflict_cnt;

    // Free-running wrap-around activity counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stat_core_cnt     <= '0;
            r_stat_dbg_cnt      <= '0;
            r_stat_conflict_cnt <= '0;
        end else begin
            if (w_core_gnt) r_stat_core_cnt <= r_stat_core_cnt + 32'(1);
            if (w_dbg_gnt)  r_stat_dbg_cnt  <= r_stat_dbg_cnt + 32'(1);
            if (i_core_req && i_dbg_req) begin
                r_stat_conflict_cnt <= r_stat_conflict_cnt + 32'(1);
            end
        end
    end

    assign o_stat_core_cnt     = r_stat_core_cnt;
    assign o_stat_dbg_cnt      = r_stat_dbg_cnt;
    assign o_stat_conflict_cnt = r_stat_conflict_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, then randomized traffic
// checked against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct {
        bit          rst_n;
        bit          creq;
        bit          cwe;
        logic [7:0]  caddr;
        logic [31:0] cwd;
        bit          dreq;
        bit          dwe;
        logic [7:0]  daddr;
        logic [31:0] dwd;
        bit          e_cg;
        bit          e_dg;
        bit          e_st;
        bit          e_crv;
        logic [31:0] e_crd;
        bit          e_drv;
        logic [31:0] e_drd;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [7:0]  core_addr, dbg_addr;
    logic [31:0] core_wdata, dbg_wdata;
    logic        o_core_gnt, o_core_stall, o_core_rvalid;
    logic [31:0] o_core_rdata;
    logic        o_dbg_gnt, o_dbg_rvalid;
    logic [31:0] o_dbg_rdata;
    logic        o_mem_en, o_mem_we;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] mem_rdata_q;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_core, stat_dbg, stat_conf;
`endif

    dmem_arbiter #(
        .P_DATA_WIDTH      (32),
        .P_DMEM_ADDR_WIDTH (8),
        .P_MAX_WAIT        (MAX_WAIT)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_core_req    (core_req),
        .i_core_we     (core_we),
        .i_core_addr   (core_addr),
        .i_core_wdata  (core_wdata),
        .o_core_gnt    (o_core_gnt),
        .o_core_stall  (o_core_stall),
        .o_core_rvalid (o_core_rvalid),
        .o_core_rdata  (o_core_rdata),
        .i_dbg_req     (dbg_req),
        .i_dbg_we      (dbg_we),
        .i_dbg_addr    (dbg_addr),
        .i_dbg_wdata   (dbg_wdata),
        .o_dbg_gnt     (o_dbg_gnt),
        .o_dbg_rvalid  (o_dbg_rvalid),
        .o_dbg_rdata   (o_dbg_rdata),
        .o_mem_en      (o_mem_en),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_rdata   (mem_rdata_q)
`ifdef DMEM_ARB_STATS_EN
        ,
        .o_stat_core_cnt     (stat_core),
        .o_stat_dbg_cnt      (stat_dbg),
        .o_stat_conflict_cnt (stat_conf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] preload(input int i);
        case (i)
            1:       return 32'd11;
            2:       return 32'd22;
            100:     return 32'd25;
            default: return 32'(i * 7 + 3);
        endcase
    endfunction

    // Environment: synchronous-read data memory driven by the DUT.
    logic [31:0] mem [256];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= preload(i);
            mem_init <= 1'b1;
        end else if (o_mem_en) begin
            if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
            else          mem_rdata_q     <= mem[o_mem_addr];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [256];
    int          m_wait;
    int          m_pend;      // 0 none, 1 core, 2 debug
    logic [31:0] m_pdata;
    bit          last_cg, last_dg;
    int          n_vec, n_err, cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input bit tab);
        bit          cwin, dwin, x_st, x_en, x_we, x_crv, x_drv;
        logic [7:0]  x_addr;
        logic [31:0] x_wd, x_crd, x_drd;
        rst_n      = v.rst_n;
        core_req   = v.creq;  core_we  = v.cwe;  core_addr = v.caddr;  core_wdata = v.cwd;
        dbg_req    = v.dreq;  dbg_we   = v.dwe;  dbg_addr  = v.daddr;  dbg_wdata  = v.dwd;
        @(negedge clk);
        dwin   = v.rst_n && v.dreq && (!v.creq || m_wait >= MAX_WAIT);
        cwin   = v.rst_n && v.creq && !dwin;
        x_st   = v.rst_n && v.creq && !cwin;
        x_en   = cwin || dwin;
        x_we   = cwin ? v.cwe : (dwin ? v.dwe : 1'b0);
        x_addr = dwin ? v.daddr : v.caddr;
        x_wd   = dwin ? v.dwd : v.cwd;
        x_crv  = v.rst_n && (m_pend == 1);
        x_drv  = v.rst_n && (m_pend == 2);
        x_crd  = x_crv ? m_pdata : 32'd0;
        x_drd  = x_drv ? m_pdata : 32'd0;
        chk("core_gnt",    32'(o_core_gnt),    32'(cwin));
        chk("dbg_gnt",     32'(o_dbg_gnt),     32'(dwin));
        chk("core_stall",  32'(o_core_stall),  32'(x_st));
        chk("mem_en",      32'(o_mem_en),      32'(x_en));
        chk("mem_we",      32'(o_mem_we),      32'(x_we));
        chk("mem_addr",    32'(o_mem_addr),    32'(x_addr));
        chk("mem_wdata",   o_mem_wdata,        x_wd);
        chk("core_rvalid", 32'(o_core_rvalid), 32'(x_crv));
        chk("core_rdata",  o_core_rdata,       x_crd);
        chk("dbg_rvalid",  32'(o_dbg_rvalid),  32'(x_drv));
        chk("dbg_rdata",   o_dbg_rdata,        x_drd);
        if (tab) begin
            chk("tab_core_gnt",    32'(o_core_gnt),    32'(v.e_cg));
            chk("tab_dbg_gnt",     32'(o_dbg_gnt),     32'(v.e_dg));
            chk("tab_core_stall",  32'(o_core_stall),  32'(v.e_st));
            chk("tab_core_rvalid", 32'(o_core_rvalid), 32'(v.e_crv));
            chk("tab_core_rdata",  o_core_rdata,       v.e_crd);
            chk("tab_dbg_rvalid",  32'(o_dbg_rvalid),  32'(v.e_drv));
            chk("tab_dbg_rdata",   o_dbg_rdata,        v.e_drd);
        end
        if (!v.rst_n) begin
            m_wait = 0;
            m_pend = 0;
        end else begin
            m_pend = 0;
            if (cwin) begin
                if (v.cwe) ref_mem[v.caddr] = v.cwd;
                else begin m_pend = 1; m_pdata = ref_mem[v.caddr]; end
            end
            if (dwin) begin
                if (v.dwe) ref_mem[v.daddr] = v.dwd;
                else begin m_pend = 2; m_pdata = ref_mem[v.daddr]; end
            end
            if (dwin) m_wait = 0;
            else if (v.dreq && m_wait < MAX_WAIT) m_wait++;
        end
        last_cg = cwin;
        last_dg = dwin;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit r, bit cq, bit cw, int ca, logic [31:0] cd,
                                bit dq, bit dw, int da, logic [31:0] dd,
                                bit cg, bit dg, bit st, bit crv, logic [31:0] crd,
                                bit drv, logic [31:0] drd);
        vec_t v;
        v.rst_n = r;  v.creq = cq; v.cwe = cw; v.caddr = 8'(ca); v.cwd = cd;
        v.dreq = dq;  v.dwe = dw;  v.daddr = 8'(da); v.dwd = dd;
        v.e_cg = cg;  v.e_dg = dg; v.e_st = st;
        v.e_crv = crv; v.e_crd = crd; v.e_drv = drv; v.e_drd = drd;
        return v;
    endfunction

    vec_t tab[$];

    initial begin
        vec_t v;
        bit   cp, dp;
        n_vec = 0; n_err = 0; cyc = 0;
        m_wait = 0; m_pend = 0; m_pdata = '0;
        last_cg = 1'b0; last_dg = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);

        //               rst cq cw ca   cd            dq dw da dd            cg dg st crv crd           drv drd
        tab.push_back(mk(0, 0, 0, 0,   0,            0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 0));
        tab.push_back(mk(0, 0, 0, 0,   0,            0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 0));
        tab.push_back(mk(1, 1, 0, 100, 0,            0, 0, 0, 0,            1, 0, 0, 0, 0,            0, 0));
        tab.push_back(mk(1, 0, 0, 0,   0,            0, 0, 0, 0,            0, 0, 0, 1, 25,           0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            1, 0, 2, 0,            1, 0, 0, 0, 0,            0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            1, 0, 2, 0,            1, 0, 0, 1, 11,           0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            1, 0, 2, 0,            1, 0, 0, 1, 11,           0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            1, 0, 2, 0,            1, 0, 0, 1, 11,           0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            1, 0, 2, 0,            0, 1, 1, 1, 11,           0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            1, 0, 2, 0,            1, 0, 0, 0, 0,            1, 22));
        tab.push_back(mk(1, 0, 0, 0,   0,            1, 1, 96, 32'hDEADBEEF, 0, 1, 0, 1, 11,          0, 0));
        tab.push_back(mk(1, 1, 0, 96,  0,            0, 0, 0, 0,            1, 0, 0, 0, 0,            0, 0));
        tab.push_back(mk(1, 0, 0, 0,   0,            0, 0, 0, 0,            0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            0, 0, 0, 0,            1, 0, 0, 0, 0,            0, 0));
        tab.push_back(mk(1, 0, 0, 0,   0,            1, 0, 2, 0,            0, 1, 0, 1, 11,           0, 0));
        tab.push_back(mk(1, 0, 0, 0,   0,            0, 0, 0, 0,            0, 0, 0, 0, 0,            1, 22));
        tab.push_back(mk(1, 1, 0, 100, 0,            1, 0, 2, 0,            1, 0, 0, 0, 0,            0, 0));
        tab.push_back(mk(0, 1, 0, 100, 0,            1, 0, 2, 0,            0, 0, 0, 0, 0,            0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            1, 0, 2, 0,            1, 0, 0, 0, 0,            0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            1, 0, 2, 0,            1, 0, 0, 1, 11,           0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            1, 0, 2, 0,            1, 0, 0, 1, 11,           0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            1, 0, 2, 0,            1, 0, 0, 1, 11,           0, 0));
        tab.push_back(mk(1, 1, 0, 1,   0,            1, 0, 2, 0,            0, 1, 1, 1, 11,           0, 0));
        tab.push_back(mk(1, 0, 0, 0,   0,            0, 0, 0, 0,            0, 0, 0, 0, 0,            1, 22));

        @(posedge clk);
        #1;
        foreach (tab[i]) apply(tab[i], 1'b1);

        // Randomized traffic honouring the hold-until-grant protocol.
        v  = tab[0];
        cp = 1'b0;
        dp = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (cp && $urandom_range(0, 19) == 0) cp = 1'b0;
            if (dp && $urandom_range(0, 19) == 0) dp = 1'b0;
            if (!cp && $urandom_range(0, 2) != 0) begin
                cp = 1'b1;
                v.cwe = 1'($urandom_range(0, 1));
                v.caddr = 8'($urandom_range(0, 15));
                v.cwd = $urandom;
            end
            if (!dp && $urandom_range(0, 1) != 0) begin
                dp = 1'b1;
                v.dwe = 1'($urandom_range(0, 1));
                v.daddr = 8'($urandom_range(0, 15));
                v.dwd = $urandom;
            end
            v.creq  = cp;
            v.dreq  = dp;
            v.rst_n = ($urandom_range(0, 99) != 0);
            apply(v, 1'b0);
            if (last_cg) cp = 1'b0;
            if (last_dg) dp = 1'b0;
        end

`ifdef DMEM_ARB_STATS_EN
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply(mk(1, 1, 0, 3, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        end
        chk("stat_core",     stat_core, 32'd8);
        chk("stat_dbg",      stat_dbg,  32'd2);
        chk("stat_conflict", stat_conf, 32'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
